// File: rtl/cic_pkg.sv
// Shared CIC definitions: output-width rule and the common wide sample type.
// Used by both the interpolation and decimation chains.
package cic_pkg;

    localparam int CIC_SAMPLE_MAX_W = 64;

    typedef logic signed [CIC_SAMPLE_MAX_W-1:0] cic_sample_t;

    // Register growth of a CIC chain: one $clog2(R*M) step per stage.
    function automatic int cic_out_width(input int win, input int n, input int r, input int m);
        return win + n * $clog2(r * m);
    endfunction

endpackage

// File: rtl/cic_int_stage.sv
// One wrapping integrator stage: y accumulates x on every enabled cycle.
// Latency 1 cycle; holds its value whenever en is low.
module cic_int_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y
);

    always_ff @(posedge clk) begin
        if (rst) begin
            y <= '0;
        end else if (en) begin
            y <= y + x;
        end
    end

endmodule

// File: rtl/cic_interpolator.sv
// CIC interpolator: N comb stages at input rate, zero-stuff by R, N integrators at output rate.
// Output sample k of a group appears one cycle after its slot; out_ready low freezes all state.
module cic_interpolator
    import cic_pkg::*;
#(
    parameter  int WIDTH_IN  = 8,
    parameter  int N_STAGES  = 3,
    parameter  int R         = 4,
    parameter  int M         = 1,
    localparam int WIDTH_OUT = cic_out_width(WIDTH_IN, N_STAGES, R, M)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH_IN-1:0]  in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [WIDTH_OUT-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int PHASE_W = (R > 1) ? $clog2(R) : 1;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(R - 1);

    logic                        in_fire;
    logic                        out_fire;
    logic                        slot;
    logic                        last_phase;
    logic                        up_valid;
    logic [PHASE_W-1:0]          phase;
    logic signed [WIDTH_OUT-1:0] up_reg;
    logic signed [WIDTH_OUT-1:0] in_ext;
    logic signed [WIDTH_OUT-1:0] comb_out;
    logic signed [WIDTH_OUT-1:0] integ_x;

    assign slot       = up_valid & (!out_valid | out_ready);
    assign last_phase = (phase == PHASE_LAST);
    assign in_ready   = !up_valid | (slot & last_phase);
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    assign in_ext = {{(WIDTH_OUT-WIDTH_IN){in_data[WIDTH_IN-1]}}, in_data};

    // Comb section runs at the input rate; its delay lines only move on accepted samples.
    for (genvar k = 0; k < N_STAGES; k++) begin : g_comb
        logic signed [WIDTH_OUT-1:0] c_in;
        logic signed [WIDTH_OUT-1:0] c_out;
        logic signed [WIDTH_OUT-1:0] dly [M];

        if (k == 0) begin : g_first
            assign c_in = in_ext;
        end else begin : g_chain
            assign c_in = g_comb[k-1].c_out;
        end

        assign c_out = c_in - dly[M-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int j = 0; j < M; j++) begin
                    dly[j] <= '0;
                end
            end else if (in_fire) begin
                dly[0] <= c_in;
                for (int j = 1; j < M; j++) begin
                    dly[j] <= dly[j-1];
                end
            end
        end
    end

    assign comb_out = g_comb[N_STAGES-1].c_out;

    // Zero-stuffing: the held comb result enters the integrators only on phase 0.
    assign integ_x = (phase == '0) ? up_reg : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            up_reg    <= '0;
            up_valid  <= 1'b0;
            phase     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (slot) begin
                out_valid <= 1'b1;
                if (last_phase) begin
                    phase    <= '0;
                    up_valid <= 1'b0;
                end else begin
                    phase <= phase + PHASE_W'(1);
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            // A new sample arriving on the last phase starts the next group back-to-back.
            if (in_fire) begin
                up_reg   <= comb_out;
                up_valid <= 1'b1;
                phase    <= '0;
            end
        end
    end

    // Integrators are pipelined: each stage adds the previous stage's registered value.
    for (genvar k = 0; k < N_STAGES; k++) begin : g_int
        logic [WIDTH_OUT-1:0] sx;
        logic [WIDTH_OUT-1:0] sy;

        if (k == 0) begin : g_first
            assign sx = integ_x;
        end else begin : g_chain
            assign sx = g_int[k-1].sy;
        end

        cic_int_stage #(
            .WIDTH (WIDTH_OUT)
        ) u_stage (
            .clk (clk),
            .rst (rst),
            .en  (slot),
            .x   (sx),
            .y   (sy)
        );
    end

    assign out_data = g_int[N_STAGES-1].sy;

endmodule

// File: doc/cic_interpolator.md
CIC_INTERPOLATOR -- requirements
Module: cic_interpolator

Interface
REQ-001 SHALL have parameter WIDTH_IN, default 8, signed two's-complement input sample width.
REQ-002 SHALL have parameter N_STAGES, default 3, number of comb stages and number of integrator stages.
REQ-003 SHALL have parameter R, default 4, interpolation ratio (>=2).
REQ-004 SHALL have parameter M, default 1, comb differential delay (1 or 2).
REQ-005 SHALL have localparam WIDTH_OUT = WIDTH_IN + N_STAGES*$clog2(R*M), the internal and output width.
REQ-006 Ports, clock and reset first; one clock; reset is synchronous and active-high:
  clk        in   1          sole clock, all state on posedge
  rst        in   1          synchronous active-high reset
  in_data    in   WIDTH_IN   signed input sample
  in_valid   in   1          input sample offered
  in_ready   out  1          block accepts input this cycle
  out_data   out  WIDTH_OUT  signed output sample
  out_valid  out  1          out_data holds an unconsumed sample
  out_ready  in   1          consumer takes out_data this cycle

Function
REQ-007 SHALL define in_fire = in_valid & in_ready, out_fire = out_valid & out_ready, slot = up_valid & (!out_valid | out_ready).
REQ-008 Comb section SHALL sign-extend in_data to WIDTH_OUT; stage k output c_k = c_(k-1) - c_(k-1) delayed by M accepted inputs; delay lines advance only on in_fire.
REQ-009 On in_fire, SHALL load up_reg <= c_N, set up_valid <= 1 and phase <= 0.
REQ-010 Integrator input x SHALL be up_reg when phase == 0, otherwise 0 (zero-stuffing).
REQ-011 On slot, integrators SHALL update in pipelined form: I_1 <= I_1 + x, I_k <= I_k + I_(k-1) (pre-update values); out_data = I_N register.
REQ-012 On slot, phase SHALL increment; on slot with phase == R-1, SHALL set phase <= 0 and up_valid <= 0, unless in_fire in the same cycle (REQ-009 wins).
REQ-013 in_ready SHALL equal !up_valid | (slot & phase == R-1), giving gapless throughput of one input per R outputs.
REQ-014 out_valid SHALL be set on slot, cleared on out_fire without slot, and held otherwise; out_data SHALL be stable while out_valid & !out_ready.
REQ-015 With out_ready low and out_valid high, no integrator, phase or comb state SHALL change.
REQ-016 All adds/subtracts SHALL wrap modulo 2^WIDTH_OUT; no saturation or overflow flag.
REQ-017 Steady-state DC gain SHALL be (R*M)^N_STAGES / R; the output sequence is fixed-latency relative to the slot count.

Reset
REQ-018 While rst is high at posedge clk, SHALL clear comb delay lines, up_reg, integrators, phase, up_valid and out_valid; out_data = 0, out_valid = 0, and in_ready = 1 from the first cycle after reset.
REQ-019 Reset asserted mid-group SHALL discard the pending sample and remaining zero-stuffed phases; no output is produced until a new in_fire.

Structure
REQ-020 Package cic_pkg SHALL hold the width function cic_out_width(win, n, r, m) and the shared signed sample typedef, used also by the decimation chain.
REQ-021 One sub-module cic_int_stage (parameter WIDTH; ports clk, rst, en, x, y) SHALL be instantiated N_STAGES times; the comb section and rate control SHALL remain in cic_interpolator.

Verification
REQ-022 N=1, R=4, M=1, out_ready=1: in_data = 1 then 0s -> out_data sequence 1,1,1,1,0,0,0,0.
REQ-023 N=2, R=2, M=1, constant in_data = 5, out_ready=1 -> out_data settles at 10 after transient; in_valid asserted every cycle -> in_ready high exactly once per 2 cycles.
REQ-024 Backpressure: out_ready held low for 5 cycles mid-group -> out_data and out_valid unchanged, in_ready low, sample count unchanged after release.
REQ-025 WIDTH_IN=8, N=3, R=4: in_data alternating -128/+127 -> output matches a wrapping golden model bit-exactly, no X.
REQ-026 rst asserted at phase 2 of a group -> next cycle out_valid=0, out_data=0, in_ready=1; next impulse reproduces REQ-022 response.
